// File: rtl/mac_sequencer.sv
// Buffers N pixel/weight pairs, streams them into an external MAC one per cycle,
// then presents the MAC's accumulated Q8.8 dot product until the consumer takes it.
module mac_sequencer #(
    parameter int unsigned N  = 9,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_pixel,
    input  logic [DW-1:0] load_weight,
    output logic [DW-1:0] mac_pixel,
    output logic [DW-1:0] mac_weight,
    output logic          mac_clear,
    input  logic [DW-1:0] mac_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] pix_q [N];
    logic [DW-1:0] pix_d [N];
    logic [DW-1:0] wgt_q [N];
    logic [DW-1:0] wgt_d [N];

    logic in_load, in_run, in_done, load_fire;

    assign in_load   = (state_q == S_LOAD) && !reset;
    assign in_run    = (state_q == S_RUN)  && !reset;
    assign in_done   = (state_q == S_DONE) && !reset;
    assign load_fire = load_valid && load_ready;

    // Interface outputs decode directly from state; reset forces the safe values.
    assign load_ready = in_load;
    assign mac_clear  = reset || (state_q == S_LOAD);
    assign mac_pixel  = in_run  ? pix_q[idx_q] : '0;
    assign mac_weight = in_run  ? wgt_q[idx_q] : '0;
    assign out_valid  = in_done;
    assign out_data   = in_done ? mac_result : '0;

    // Next-state, index and buffer-write logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        wgt_d   = wgt_q;
        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    pix_d[idx_q] = load_pixel;
                    wgt_d[idx_q] = load_weight;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_RUN: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Pair buffer carries no reset; every batch rewrites all N entries before RUN.
    always_ff @(posedge clk) begin
        pix_q <= pix_d;
        wgt_q <= wgt_d;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural Q8.8 MAC model attached.
module tb_mac_sequencer;

    localparam int N  = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_pixel;
    logic [DW-1:0] load_weight;
    logic [DW-1:0] mac_pixel;
    logic [DW-1:0] mac_weight;
    logic          mac_clear;
    logic [DW-1:0] mac_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    mac_sequencer #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_pixel  (load_pixel),
        .load_weight (load_weight),
        .mac_pixel   (mac_pixel),
        .mac_weight  (mac_weight),
        .mac_clear   (mac_clear),
        .mac_result  (mac_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    // Downstream MAC: registered accumulator, term = (pixel*weight)[23:8], wraps mod 2^16.
    logic [DW-1:0]      acc;
    logic signed [31:0] prod;
    assign prod       = $signed(mac_pixel) * $signed(mac_weight);
    assign mac_result = acc;
    always @(posedge clk) begin
        if (mac_clear) acc <= '0;
        else           acc <= acc + prod[23:8];
    end

    typedef struct {
        logic [15:0] pbase;
        logic [15:0] pstep;
        logic [15:0] w;
        bit          gapped;
        bit          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pix_of(input vec_t v, input int k);
        return 16'(v.pbase + v.pstep * 16'(k));
    endfunction

    // Entered and left at a negedge.
    task automatic run_vector(input vec_t v, input int id);
        int accepted = 0;
        int cyc = 0;
        int stalls = 0;
        int k = 0;
        int bad = 0;
        bit lv;
        while (accepted < N && cyc < 100) begin
            lv = !v.gapped || (cyc % 2 == 0);
            load_valid  = lv;
            load_pixel  = pix_of(v, accepted);
            load_weight = v.w;
            if (!load_ready) stalls++;
            if (lv && load_ready) accepted++;
            cyc++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        check($sformatf("v%0d accepted", id), 32'(accepted), 32'(N));
        check($sformatf("v%0d load_stalls", id), 32'(stalls), 32'd0);
        check($sformatf("v%0d run_ready_low", id), 32'(load_ready), 32'd0);
        while (!out_valid && k < 50) begin
            if (k < N && (mac_pixel !== pix_of(v, k) || mac_weight !== v.w || mac_clear !== 1'b0))
                bad++;
            @(negedge clk);
            k++;
        end
        check($sformatf("v%0d latency", id), 32'(k), 32'(N));
        check($sformatf("v%0d run_operands", id), 32'(bad), 32'd0);
        check($sformatf("v%0d out_data", id), 32'(out_data), 32'(v.exp));
        check($sformatf("v%0d done_ready_low", id), 32'(load_ready), 32'd0);
        check($sformatf("v%0d done_operands", id), 32'({mac_pixel, mac_weight}), 32'd0);
        if (v.hold) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check($sformatf("v%0d hold_valid", id), 32'(out_valid), 32'd1);
                check($sformatf("v%0d hold_data", id), 32'(out_data), 32'(v.exp));
                check($sformatf("v%0d hold_ready", id), 32'(load_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d post_valid", id), 32'(out_valid), 32'd0);
        check($sformatf("v%0d post_data", id), 32'(out_data), 32'd0);
        check($sformatf("v%0d post_ready", id), 32'(load_ready), 32'd1);
        check($sformatf("v%0d post_clear", id), 32'(mac_clear), 32'd1);
    endtask

    initial begin
        vec_t abort_v;
        vecs[0] = '{16'h0100, 16'h0000, 16'h0200, 1'b0, 1'b0, 16'h1200};
        vecs[1] = '{16'h0100, 16'h0000, 16'h2000, 1'b0, 1'b1, 16'h2000};
        vecs[2] = '{16'h0100, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'h0900};
        vecs[3] = '{16'h0080, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'h0480};
        vecs[4] = '{16'h0100, 16'h0000, 16'h0100, 1'b1, 1'b0, 16'h0900};
        vecs[5] = '{16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h2D00};
        vecs[6] = '{16'hFF00, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'hF700};
        vecs[7] = '{16'h0180, 16'h0000, 16'h0200, 1'b1, 1'b0, 16'h1B00};
        abort_v = '{16'h0100, 16'h0000, 16'h0100, 1'b0, 1'b0, 16'h0900};

        reset       = 1'b1;
        load_valid  = 1'b0;
        load_pixel  = '0;
        load_weight = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst mac_clear", 32'(mac_clear), 32'd1);
        check("rst load_ready", 32'(load_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst operands", 32'({mac_pixel, mac_weight}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle load_ready", 32'(load_ready), 32'd1);
        check("idle mac_clear", 32'(mac_clear), 32'd1);
        check("idle out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

        // Abort a running batch at idx 4, then confirm a fresh batch carries no residue.
        for (int i = 0; i < N; i++) begin
            load_valid  = 1'b1;
            load_pixel  = 16'h0200;
            load_weight = 16'h0300;
            @(negedge clk);
        end
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort running_pixel", 32'(mac_pixel), 32'h0200);
        reset = 1'b1;
        #1;
        check("abort mac_clear", 32'(mac_clear), 32'd1);
        check("abort load_ready", 32'(load_ready), 32'd0);
        check("abort operands", 32'({mac_pixel, mac_weight}), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vector(abort_v, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
